id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 156 +++++++++++++++
 tb/tb_id_ex_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register between decode and execute with a valid/ready
// handshake on both sides. The payload passes through untouched.
// Optional feature: define ID_EX_SKID_EN to add a second (skid) entry so that
// in_ready comes from a register instead of combinationally from out_ready.
// Without the macro the block is a single-entry register with
// in_ready = !out_valid | out_ready.
module id_ex_reg #(
    parameter int xlen = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [xlen-1:0] in_a,
    input  logic [xlen-1:0] in_b,
    input  logic [2:0]      in_alu_ctrl,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [xlen-1:0] out_a,
    output logic [xlen-1:0] out_b,
    output logic [2:0]      out_alu_ctrl,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic [1:0]      occupancy
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [xlen-1:0] a;
        logic [xlen-1:0] b;
        logic [2:0]      alu_ctrl;
        logic [4:0]      rd;
        logic            reg_write;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t in_entry;
    logic   accept;
    logic   issue;

    assign in_entry = '{a:         in_a,
                        b:         in_b,
                        alu_ctrl:  in_alu_ctrl,
                        rd:        in_rd,
                        reg_write: in_reg_write};

    assign out_valid     = (state_q != EMPTY);
    assign occupancy     = state_q;
    assign out_a         = main_q.a;
    assign out_b         = main_q.b;
    assign out_alu_ctrl  = main_q.alu_ctrl;
    assign out_rd        = main_q.rd;
    assign out_reg_write = main_q.reg_write;

    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;

`ifdef ID_EX_SKID_EN
    entry_t skid_q, skid_d;
    logic   in_ready_q;

    // Ready is registered from the next state, so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != TWO);
        end
    end

    assign in_ready = in_ready_q;
`else
    assign in_ready = ~out_valid | out_ready;
`endif

    // Next-state and next-payload selection from accept/issue; flush wins over both.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        main_d  = main_q;
`ifdef ID_EX_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = in_entry;
                end
            end
            ONE: begin
                if (accept && issue) begin
                    main_d = in_entry;
`ifdef ID_EX_SKID_EN
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = in_entry;
`endif
                end else if (issue) begin
                    state_d = EMPTY;
                end
            end
`ifdef ID_EX_SKID_EN
            TWO: begin
                // in_ready is low here, so only the skid-to-main move can happen.
                if (issue) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
`endif
            default: begin
                state_d = EMPTY;
            end
        endcase

        // A flushed cycle discards the accepting beat; payload registers keep their last value.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
`ifdef ID_EX_SKID_EN
            skid_d  = skid_q;
`endif
        end
    end

    // State and payload registers; reset clears everything, including the data.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= EMPTY;
            // NOTE: payload registers are reset too, so out_* read as zero after reset rather than stale data.
            main_q  <= '0;
`ifdef ID_EX_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef ID_EX_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios followed by random
// traffic. Accepted beats go into a scoreboard queue that is also the
// reference model of the held entries; a separate monitor compares out_*
// against the queue head whenever out_valid is high and pops it on issue.
module tb_id_ex_reg;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_a = '0;
    logic [XLEN-1:0] in_b = '0;
    logic [2:0]      in_alu_ctrl = '0;
    logic [4:0]      in_rd = '0;
    logic            in_reg_write = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [2:0]      out_alu_ctrl;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic [1:0]      occupancy;

    always #5 clk = ~clk;

    id_ex_reg #(.xlen(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_alu_ctrl  (in_alu_ctrl),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_alu_ctrl (out_alu_ctrl),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write),
        .occupancy    (occupancy)
    );

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      ctrl;
        logic [4:0]      rd;
        logic            rw;
    } ent_t;

    // Entries currently held by the DUT, oldest first.
    ent_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   zero_outs = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream may hand over a beat when the buffer has room.
    function automatic bit model_ready(input logic ordy);
`ifdef ID_EX_SKID_EN
        return exp_q.size() < 2;
`else
        return exp_q.size() == 0 || ordy;
`endif
    endfunction

    // One cycle of stimulus: drive at negedge, check handshake/occupancy, update the model.
    task automatic drive(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [2:0] c, input logic [4:0] rd, input logic rw,
                         input logic ordy, input logic fl, input logic rs);
        bit   rdy;
        ent_t e;
        @(negedge clk);
        in_valid     = v;
        in_a         = a;
        in_b         = b;
        in_alu_ctrl  = c;
        in_rd        = rd;
        in_reg_write = rw;
        out_ready    = ordy;
        flush        = fl;
        rst          = rs;
        #1;
        rdy = model_ready(ordy);
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("occupancy", 64'(occupancy), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (zero_outs && exp_q.size() == 0) begin
            check("reset_out_a", out_a, 64'd0);
            check("reset_out_b", out_b, 64'd0);
            check("reset_out_alu_ctrl", 64'(out_alu_ctrl), 64'd0);
            check("reset_out_rd", 64'(out_rd), 64'd0);
            check("reset_out_reg_write", 64'(out_reg_write), 64'd0);
        end
        if (!rs && !fl && v && rdy) begin
            e.a = a; e.b = b; e.ctrl = c; e.rd = rd; e.rw = rw;
            exp_q.push_back(e);
            zero_outs = 1'b0;
        end
        #2;
        if (rs || fl) exp_q.delete();
        if (rs) zero_outs = 1'b1;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, '0, '0, 3'd0, 5'd0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [XLEN-1:0] a, input logic ordy);
        drive(1'b1, a, a ^ 64'hff, a[2:0], a[4:0], a[0], ordy, 1'b0, 1'b0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !flush && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 expected 0 at %0t", $time);
                end else begin
                    check("out_a", out_a, exp_q[0].a);
                    check("out_b", out_b, exp_q[0].b);
                    check("out_alu_ctrl", 64'(out_alu_ctrl), 64'(exp_q[0].ctrl));
                    check("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
                    check("out_reg_write", 64'(out_reg_write), 64'(exp_q[0].rw));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset
        drive(1'b0, '0, '0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);

        // Single beat after reset appears one cycle later
        drive(1'b1, 64'd5, 64'd3, 3'b010, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        check("first_out_valid", 64'(out_valid), 64'd1);
        check("first_out_a", out_a, 64'd5);
        check("first_out_b", out_b, 64'd3);
        check("first_out_alu_ctrl", 64'(out_alu_ctrl), 64'd2);
        check("first_out_rd", 64'(out_rd), 64'd7);
        check("first_occupancy", 64'(occupancy), 64'd1);
        idle(1'b1);
        idle(1'b1);

`ifdef ID_EX_SKID_EN
        // Two beats held while downstream stalls, then drained in order
        push(64'd1, 1'b0);
        push(64'd2, 1'b0);
        idle(1'b0);
        check("skid_occupancy", 64'(occupancy), 64'd2);
        check("skid_in_ready", 64'(in_ready), 64'd0);
        check("skid_hold_a", out_a, 64'd1);
        idle(1'b1);
        check("skid_issue_first", out_a, 64'd1);
        idle(1'b1);
        check("skid_issue_second", out_a, 64'd2);
        idle(1'b1);
        check("skid_drained", 64'(occupancy), 64'd0);
`else
        // Combinational ready follows out_ready while full
        push(64'd4, 1'b0);
        idle(1'b0);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        push(64'd9, 1'b1);
        check("pass_in_ready", 64'(in_ready), 64'd1);
        idle(1'b0);
        check("pass_out_a", out_a, 64'd9);
        idle(1'b1);
        idle(1'b1);
`endif

        // Streaming at full rate
        for (int i = 1; i <= 10; i++) push(64'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while full and downstream ready
        push(64'h31, 1'b0);
        push(64'h32, 1'b0);
        drive(1'b1, 64'h33, '0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_occupancy", 64'(occupancy), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        idle(1'b1);

        // Reset mid-transfer
        push(64'h11, 1'b0);
        drive(1'b1, 64'h22, 64'h22, 3'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_a", out_a, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 9) < 7),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  3'($urandom), 5'($urandom), 1'($urandom),
                  1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 59) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
